// File: rtl/sparse_rle_decoder.sv
// Purpose : expands (value, zero-run) pairs of one channel into a dense,
//           position-addressed activation stream of dense_len words.
// Latency : first dense word valid the cycle after a pair is accepted; one
//           FETCH bubble per pair. done pulses the cycle after the final handshake.
// Backpres: out_data/out_addr/out_last hold while out_valid && !out_ready;
//           in_ready depends on state only, never on out_ready.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   start, dense_len       channel start pulse (IDLE only) and dense length
//   in_valid/in_ready      compressed pair handshake: in_data, in_index, in_last
//   out_valid/out_ready    dense word handshake: out_data, out_addr, out_last
//   busy, done, overflow   status: not idle, completion pulse, sticky overrun

module sparse_rle_decoder #(
   parameter int DATA_W = 16,
   parameter int IDX_W  = 4,
   parameter int LEN_W  = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [LEN_W-1:0]         dense_len,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic [IDX_W-1:0]         in_index,
   input  logic                     in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_data,
   output logic [LEN_W-1:0]         out_addr,
   output logic                     out_last,
   output logic                     busy,
   output logic                     done,
   output logic                     overflow
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_ZERO  = 3'd2;
   localparam logic [2:0] S_VAL   = 3'd3;
   localparam logic [2:0] S_PAD   = 3'd4;
   localparam logic [2:0] S_DRAIN = 3'd5;

   logic [2:0]               state;
   logic [LEN_W-1:0]         len;
   logic [LEN_W-1:0]         pos;
   logic [IDX_W-1:0]         run_cnt;
   logic signed [DATA_W-1:0] data_q;
   logic                     last_seen;

   logic out_hs;
   logic at_end;

   assign out_hs = out_valid && out_ready;
   // Only meaningful in emitting states, where len is always >= 1.
   assign at_end = (pos == len - LEN_W'(1));

   assign in_ready  = (state == S_FETCH) || (state == S_DRAIN);
   assign out_valid = (state == S_ZERO) || (state == S_VAL) || (state == S_PAD);
   assign out_data  = (state == S_VAL) ? data_q : '0;
   assign out_addr  = pos;
   assign out_last  = out_valid && at_end;
   assign busy      = (state != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         len       <= '0;
         pos       <= '0;
         run_cnt   <= '0;
         data_q    <= '0;
         last_seen <= 1'b0;
         done      <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  len       <= dense_len;
                  pos       <= '0;
                  run_cnt   <= '0;
                  last_seen <= 1'b0;
                  overflow  <= 1'b0;
                  if (dense_len == '0) begin
                     done <= 1'b1;
                  end else begin
                     state <= S_FETCH;
                  end
               end
            end

            S_FETCH: begin
               if (in_valid) begin
                  data_q    <= in_data;
                  run_cnt   <= in_index;
                  last_seen <= in_last;
                  state     <= (in_index != '0) ? S_ZERO : S_VAL;
               end
            end

            S_ZERO: begin
               if (out_hs) begin
                  pos     <= pos + LEN_W'(1);
                  run_cnt <= run_cnt - IDX_W'(1);
                  if (at_end) begin
                     // Dense buffer full mid-run: the rest of the pair is dropped.
                     if (last_seen) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                     end else begin
                        state    <= S_DRAIN;
                        overflow <= 1'b1;
                     end
                  end else if (run_cnt == IDX_W'(1)) begin
                     state <= S_VAL;
                  end
               end
            end

            S_VAL: begin
               if (out_hs) begin
                  pos <= pos + LEN_W'(1);
                  if (at_end) begin
                     if (last_seen) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                     end else begin
                        state    <= S_DRAIN;
                        overflow <= 1'b1;
                     end
                  end else if (last_seen) begin
                     state <= S_PAD;
                  end else begin
                     state <= S_FETCH;
                  end
               end
            end

            S_PAD: begin
               if (out_hs) begin
                  pos <= pos + LEN_W'(1);
                  if (at_end) begin
                     state <= S_IDLE;
                     done  <= 1'b1;
                  end
               end
            end

            S_DRAIN: begin
               // Swallow surplus pairs so the upstream reader ends on a channel boundary.
               if (in_valid && in_last) begin
                  state <= S_IDLE;
                  done  <= 1'b1;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sparse_rle_decoder.sv
// Purpose : self-checking bench for sparse_rle_decoder (table vectors, corner
//           sequences, randomized channels against a dense-expansion model).
// Latency : n/a. Backpres: random out_ready and in_valid gaps.

module tb_sparse_rle_decoder;

   localparam int DATA_W = 16;
   localparam int IDX_W  = 4;
   localparam int LEN_W  = 10;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     start;
   logic [LEN_W-1:0]         dense_len;
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_data;
   logic [IDX_W-1:0]         in_index;
   logic                     in_last;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [DATA_W-1:0] out_data;
   logic [LEN_W-1:0]         out_addr;
   logic                     out_last;
   logic                     busy;
   logic                     done;
   logic                     overflow;

   sparse_rle_decoder #(.DATA_W(DATA_W), .IDX_W(IDX_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst), .start(start), .dense_len(dense_len),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_index(in_index), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_addr(out_addr), .out_last(out_last),
      .busy(busy), .done(done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   int q_d[$];
   int q_ix[$];
   int exp_q[$];
   int got_d[$];
   int got_a[$];
   int got_l[$];
   int done_cnt;
   int ovf_at_done;
   int pairs_taken;

   typedef struct {
      int len;
      int np;
      int d[4];
      int ix[4];
      int exp[24];
      int ovf;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: concatenate each pair as (index zeros, value), truncate/pad to len.
   // Overrun happens when a non-final pair still covers position len-1.
   task automatic model(input int len, output int eovf);
      int pre;
      pre = 0;
      exp_q.delete();
      for (int k = 0; k < q_d.size(); k++) begin
         for (int z = 0; z < q_ix[k]; z++) exp_q.push_back(0);
         exp_q.push_back(q_d[k]);
         if (k < q_d.size() - 1) pre += q_ix[k] + 1;
      end
      while (exp_q.size() > len) void'(exp_q.pop_back());
      while (exp_q.size() < len) exp_q.push_back(0);
      eovf = (pre >= len) ? 1 : 0;
   endtask

   task automatic idle_inputs();
      start     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_index  = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
   endtask

   // Drives one channel from q_d/q_ix. Called at posedge+1.
   task automatic run_channel(input int len, input int rdy_pct, input int vld_pct,
                              input int inj_cyc, input int abort_word);
      int  pi;
      int  n;
      int  tmp;
      bit  fin;
      bit  stalled;
      int  s_d, s_a, s_l;
      n = q_d.size();
      pi = 0; fin = 0; stalled = 0; s_d = 0; s_a = 0; s_l = 0;
      got_d.delete(); got_a.delete(); got_l.delete();
      done_cnt = 0; ovf_at_done = -1;
      start = 1'b1;
      dense_len = len[LEN_W-1:0];
      @(posedge clk); #1;
      start = 1'b0;
      dense_len = ~dense_len;   // must not matter once latched
      for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
         in_valid = (pi < n) && ($urandom_range(99) < vld_pct);
         if (pi < n) begin
            tmp = q_d[pi];  in_data  = tmp[DATA_W-1:0];
            tmp = q_ix[pi]; in_index = tmp[IDX_W-1:0];
         end
         in_last   = (pi == n - 1);
         out_ready = ($urandom_range(99) < rdy_pct);
         start     = (cyc == inj_cyc);
         if (cyc == inj_cyc) dense_len = 3;
         @(negedge clk);
         if (cyc == 0) begin
            chk("busy_after_start", busy, 1);
            chk("in_ready_after_start", in_ready, 1);
         end
         if (stalled) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, s_d);
            chk("stall_addr", out_addr, s_a);
            chk("stall_last", out_last, s_l);
         end
         stalled = out_valid && !out_ready;
         s_d = out_data; s_a = out_addr; s_l = out_last;
         if (out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_a.push_back(out_addr);
            got_l.push_back(out_last);
         end
         if (in_valid && in_ready) pi++;
         if (done) begin
            done_cnt++;
            ovf_at_done = overflow;
            chk("busy_low_at_done", busy, 0);
            fin = 1;
         end
         if (abort_word >= 0 && got_d.size() == abort_word) begin
            rst = 1'b1;
            #1;
            chk("abort_out_valid", out_valid, 0);
            chk("abort_out_data", out_data, 0);
            chk("abort_out_addr", out_addr, 0);
            chk("abort_out_last", out_last, 0);
            chk("abort_in_ready", in_ready, 0);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            fin = 1;
         end
         @(posedge clk); #1;
      end
      pairs_taken = pi;
      idle_inputs();
      if (!fin) chk("channel_timeout", 0, 1);
      if (abort_word < 0) begin
         @(negedge clk);
         chk("done_one_cycle", done, 0);
         @(posedge clk); #1;
      end
   endtask

   task automatic verify(input string tag, input int len, input int eovf);
      chk({tag, "_done_cnt"}, done_cnt, 1);
      chk({tag, "_overflow"}, ovf_at_done, eovf);
      chk({tag, "_pairs"}, pairs_taken, q_d.size());
      chk({tag, "_words"}, got_d.size(), len);
      for (int i = 0; i < got_d.size() && i < len; i++) begin
         chk($sformatf("%s_w%0d_data", tag, i), got_d[i], exp_q[i]);
         chk($sformatf("%s_w%0d_addr", tag, i), got_a[i], i);
         chk($sformatf("%s_w%0d_last", tag, i), got_l[i], (i == len - 1) ? 1 : 0);
      end
   endtask

   task automatic load_vec(input int v);
      q_d.delete(); q_ix.delete(); exp_q.delete();
      for (int k = 0; k < tbl[v].np; k++) begin
         q_d.push_back(tbl[v].d[k]);
         q_ix.push_back(tbl[v].ix[k]);
      end
      for (int i = 0; i < tbl[v].len; i++) exp_q.push_back(tbl[v].exp[i]);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int eovf;
      int len;
      int n;
      int d;
      int ix;
      bit seen_rdy;

      tbl[0] = '{len:8,  np:3, d:'{5, -3, 7, 0}, ix:'{2, 0, 1, 0},
                 exp:'{2:5, 3:-3, 5:7, default:0}, ovf:0};
      tbl[1] = '{len:20, np:2, d:'{0, 9, 0, 0},  ix:'{15, 3, 0, 0},
                 exp:'{19:9, default:0}, ovf:0};
      tbl[2] = '{len:4,  np:3, d:'{1, 2, 3, 0},  ix:'{2, 3, 0, 0},
                 exp:'{2:1, default:0}, ovf:1};
      tbl[3] = '{len:3,  np:2, d:'{4, 6, 0, 0},  ix:'{1, 0, 0, 0},
                 exp:'{1:4, 2:6, default:0}, ovf:0};
      tbl[4] = '{len:5,  np:1, d:'{0, 0, 0, 0},  ix:'{15, 0, 0, 0},
                 exp:'{default:0}, ovf:0};
      tbl[5] = '{len:6,  np:1, d:'{-1, 0, 0, 0}, ix:'{0, 0, 0, 0},
                 exp:'{0:-1, default:0}, ovf:0};

      rst = 1'b1;
      dense_len = '0;
      idle_inputs();
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_addr", out_addr, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_overflow", overflow, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Table vectors, full-rate consumer and producer.
      for (int v = 0; v < 6; v++) begin
         load_vec(v);
         run_channel(tbl[v].len, 100, 100, -1, -1);
         verify($sformatf("vec%0d", v), tbl[v].len, tbl[v].ovf);
      end

      // Zero-length channel: done at T+1, in_ready never asserts.
      start = 1'b1; dense_len = '0;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("len0_done", done, 1);
      chk("len0_busy", busy, 0);
      seen_rdy = in_ready;
      repeat (3) begin
         @(negedge clk);
         seen_rdy |= in_ready;
      end
      chk("len0_in_ready_never", seen_rdy, 0);
      chk("len0_done_cleared", done, 0);
      @(posedge clk); #1;

      // Pair accepted at edge A -> first dense word valid from A+1.
      start = 1'b1; dense_len = 10'd8;
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b1; in_data = 16'sd5; in_index = 4'd2; in_last = 1'b0;
      @(negedge clk);
      chk("lat_in_ready", in_ready, 1);
      chk("lat_no_word_yet", out_valid, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("lat_first_valid", out_valid, 1);
      chk("lat_first_addr", out_addr, 0);
      chk("lat_first_data", out_data, 0);
      chk("lat_in_ready_low", in_ready, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // start pulsed while busy is ignored.
      load_vec(0);
      run_channel(8, 100, 100, 2, -1);
      verify("busy_start", 8, 0);

      // Reset at output word 3, then a clean replay.
      load_vec(0);
      run_channel(8, 100, 100, -1, 3);
      chk("abort_no_done", done_cnt, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      load_vec(0);
      run_channel(8, 100, 100, -1, -1);
      verify("replay", 8, 0);

      // Stalled replay of the table vectors.
      for (int v = 0; v < 6; v++) begin
         load_vec(v);
         run_channel(tbl[v].len, 50, 70, -1, -1);
         verify($sformatf("vecstall%0d", v), tbl[v].len, tbl[v].ovf);
      end

      // Randomized channels; r==0 resembles a 27x27 feature map.
      for (int r = 0; r < 6; r++) begin
         q_d.delete(); q_ix.delete();
         len = (r == 0) ? 729 : $urandom_range(200, 1);
         n   = (r == 0) ? 219 : $urandom_range(len / 4 + 3, 1);
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(15) == 0) begin
               d = 0; ix = 15;
            end else begin
               d = int'($urandom_range(65535)) - 32768;
               if (d == 0) d = 1;
               ix = (r == 0) ? $urandom_range(4) : $urandom_range(15);
            end
            q_d.push_back(d);
            q_ix.push_back(ix);
         end
         model(len, eovf);
         run_channel(len, 50, 70, -1, -1);
         verify($sformatf("rand%0d", r), len, eovf);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
